// File: rtl/game_ctl_if.sv
// game_ctl_if: control inputs, status outputs and RGB streams between game_ctl and its neighbours.
interface game_ctl_if #(
    parameter int SCORE_DIGITS = 2
);
    logic                      frame_tick;
    logic                      start_click;
    logic                      peer_start;
    logic                      hit;
    logic                      stop_click;
    logic [11:0]               rgb_idle;
    logic [11:0]               rgb_wait;
    logic [11:0]               rgb_game;
    logic [11:0]               rgb_score;
    logic [1:0]                state;
    logic [11:0]               rgb_out;
    logic [7:0]                round_cnt;
    logic [11:0]               round_timer;
    logic [4*SCORE_DIGITS-1:0] score_bcd;
    logic                      new_target;
    logic                      game_done;

    modport master (
        output frame_tick, start_click, peer_start, hit, stop_click,
        output rgb_idle, rgb_wait, rgb_game, rgb_score,
        input  state, rgb_out, round_cnt, round_timer, score_bcd, new_target, game_done
    );

    modport slave (
        input  frame_tick, start_click, peer_start, hit, stop_click,
        input  rgb_idle, rgb_wait, rgb_game, rgb_score,
        output state, rgb_out, round_cnt, round_timer, score_bcd, new_target, game_done
    );
endinterface

// File: rtl/game_ctl.sv
// game_ctl: duck-game sequencer (IDLE/WAIT/GAME/SCORE), round timing, BCD score and RGB select.
// Define GAME_CTL_SOLO_EN to bypass the WAIT peer handshake (single-player build).
module game_ctl #(
    parameter int ROUNDS       = 10,
    parameter int ROUND_FRAMES = 120,
    parameter int WAIT_FRAMES  = 1800,
    parameter int SCORE_DIGITS = 2
) (
    input logic       pclk,
    input logic       rst,
    game_ctl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, GAME, SCORE} state_t;
    localparam int SW = 4 * SCORE_DIGITS;

    state_t        state, state_n;
    logic [7:0]    round_cnt, round_n;
    logic [11:0]   round_timer, timer_n;
    logic [SW-1:0] score, score_n;
    logic          new_target, nt_n, game_done, gd_n;
    logic [11:0]   rgb_out;
    logic          start_q, hit_q, stop_q, start_e, hit_e, stop_e;
    logic          round_end;

    function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
        logic [SW-1:0] r;
        logic          c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < SCORE_DIGITS; i++) begin
            if (c) begin
                c = r[4*i +: 4] == 4'd9;
                r[4*i +: 4] = c ? 4'd0 : r[4*i +: 4] + 4'd1;
            end
        end
        return c ? v : r;  // carry out of the top digit means all 9s: hold
    endfunction

`ifdef GAME_CTL_SOLO_EN
    localparam state_t START_TO = GAME;
`else
    localparam state_t START_TO = WAIT;
    logic [15:0] wait_cnt;
    logic        wait_to;
    assign wait_to = bus.frame_tick && wait_cnt == 16'(WAIT_FRAMES - 1);
    always_ff @(posedge pclk or negedge rst)
        if (!rst) wait_cnt <= '0;
        else wait_cnt <= state == WAIT ? wait_cnt + (bus.frame_tick ? 16'd1 : 16'd0) : 16'd0;
`endif

    assign round_end = hit_e || (bus.frame_tick && round_timer == 12'(ROUND_FRAMES - 1));

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            round_cnt   <= '0;
            round_timer <= '0;
            score       <= '0;
            new_target  <= 1'b0;
            game_done   <= 1'b0;
            rgb_out     <= '0;
            {start_q, hit_q, stop_q} <= 3'b111;
            {start_e, hit_e, stop_e} <= 3'b000;
        end else begin
            state       <= state_n;
            round_cnt   <= round_n;
            round_timer <= timer_n;
            score       <= score_n;
            new_target  <= nt_n;
            game_done   <= gd_n;
            {start_q, hit_q, stop_q} <= {bus.start_click, bus.hit, bus.stop_click};
            {start_e, hit_e, stop_e} <= {bus.start_click, bus.hit, bus.stop_click} & ~{start_q, hit_q, stop_q};
            rgb_out <= state == IDLE ? bus.rgb_idle :
                       state == WAIT ? bus.rgb_wait :
                       state == GAME ? bus.rgb_game : bus.rgb_score;
        end
    end

    always_comb begin
        state_n = state;
        round_n = round_cnt;
        timer_n = round_timer;
        score_n = score;
        nt_n    = 1'b0;
        gd_n    = 1'b0;
        case (state)
            IDLE, SCORE: begin
                if (state == SCORE && stop_e) state_n = IDLE;
                else if (start_e) begin
                    state_n = START_TO;
                    round_n = '0;
                    timer_n = '0;
                    score_n = '0;
                    nt_n    = START_TO == GAME;
                end
            end
            WAIT: begin
`ifdef GAME_CTL_SOLO_EN
                state_n = IDLE;
`else
                if (stop_e) state_n = IDLE;
                else if (bus.peer_start) begin
                    state_n = GAME;
                    nt_n    = 1'b1;
                end else if (wait_to) state_n = IDLE;
`endif
            end
            GAME: begin
                if (stop_e) begin
                    state_n = SCORE;
                    gd_n    = 1'b1;
                end else if (round_end) begin
                    round_n = round_cnt + 8'd1;
                    timer_n = '0;
                    score_n = hit_e ? bcd_inc(score) : score;
                    gd_n    = round_n == 8'(ROUNDS);
                    nt_n    = !gd_n;
                    state_n = gd_n ? SCORE : GAME;
                end else if (bus.frame_tick) timer_n = round_timer + 12'd1;
            end
        endcase
    end

    assign bus.state       = state;
    assign bus.rgb_out     = rgb_out;
    assign bus.round_cnt   = round_cnt;
    assign bus.round_timer = round_timer;
    assign bus.score_bcd   = score;
    assign bus.new_target  = new_target;
    assign bus.game_done   = game_done;
endmodule

// File: tb/tb_game_ctl.sv
// tb_game_ctl: directed checks of game_ctl on two configurations sharing one stimulus set.
// Instance a: ROUNDS=3 ROUND_FRAMES=5 WAIT_FRAMES=4; instance b: ROUNDS=120 for score saturation.
module tb_game_ctl;
    logic pclk = 1'b0;
    logic rst  = 1'b0;
    logic tick, start, peer, hit, stop;
    int   n_chk = 0;
    int   n_fail = 0;
    int   nt_a = 0;

    always #5 pclk = ~pclk;

    game_ctl_if #(.SCORE_DIGITS(2)) ia ();
    game_ctl_if #(.SCORE_DIGITS(2)) ib ();

    assign {ia.frame_tick, ia.start_click, ia.peer_start, ia.hit, ia.stop_click} = {tick, start, peer, hit, stop};
    assign {ib.frame_tick, ib.start_click, ib.peer_start, ib.hit, ib.stop_click} = {tick, start, peer, hit, stop};
    assign {ia.rgb_idle, ia.rgb_wait, ia.rgb_game, ia.rgb_score} = {12'h111, 12'h222, 12'h333, 12'h444};
    assign {ib.rgb_idle, ib.rgb_wait, ib.rgb_game, ib.rgb_score} = {12'h111, 12'h222, 12'h333, 12'h444};

    game_ctl #(.ROUNDS(3), .ROUND_FRAMES(5), .WAIT_FRAMES(4), .SCORE_DIGITS(2))
        dut_a (.pclk(pclk), .rst(rst), .bus(ia));
    game_ctl #(.ROUNDS(120), .ROUND_FRAMES(5), .WAIT_FRAMES(4), .SCORE_DIGITS(2))
        dut_b (.pclk(pclk), .rst(rst), .bus(ib));

    task automatic cyc();
        @(posedge pclk);
        #1;
        nt_a += int'(ia.new_target);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cyc();
        cyc();
        rst = 1'b1;
        cyc();
    endtask

    task automatic press_start();
        start = 1'b1; cyc(); start = 1'b0; cyc();
    endtask

    task automatic press_stop();
        stop = 1'b1; cyc(); stop = 1'b0; cyc();
    endtask

    task automatic do_hit();
        hit = 1'b1; cyc(); hit = 1'b0; cyc();
    endtask

    task automatic do_tick();
        tick = 1'b1; cyc(); tick = 1'b0; cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        {tick, peer, hit, stop} = '0;
        start = 1'b1;
        cyc();
        cyc();
        chk("rst_state", ia.state, 0);
        chk("rst_rgb", ia.rgb_out, 0);
        chk("rst_round", ia.round_cnt, 0);
        chk("rst_timer", ia.round_timer, 0);
        chk("rst_score", ia.score_bcd, 0);
        chk("rst_pulses", {ia.new_target, ia.game_done}, 0);
        rst = 1'b1;
        cyc();
        cyc();
        chk("held_start_ignored", ia.state, 0);
        chk("rgb_idle", ia.rgb_out, 12'h111);
        start = 1'b0; cyc();
        start = 1'b1; cyc();
        chk("start_edge_lat1", ia.state, 0);
        cyc();
        chk("start_edge_lat2", ia.state, 1);
        start = 1'b0;
        cyc();
        chk("rgb_wait", ia.rgb_out, 12'h222);

        for (int i = 0; i < 4; i++) begin
            tick = 1'b1; cyc(); tick = 1'b0;
            if (i == 2) chk("wait_3_ticks", ia.state, 1);
            if (i == 3) chk("wait_timeout", ia.state, 0);
            cyc();
        end

        press_start();
        chk("restart_wait", ia.state, 1);
        do_tick();
        do_tick();
        nt_a = 0;
        peer = 1'b1; cyc(); peer = 1'b0;
        chk("peer_to_game", ia.state, 2);
        chk("peer_new_target", ia.new_target, 1);
        cyc();
        chk("new_target_1cyc", ia.new_target, 0);

        do_hit();
        chk("r1_score", ia.score_bcd, 8'h01);
        chk("r1_round", ia.round_cnt, 1);
        for (int i = 0; i < 4; i++) do_tick();
        chk("r2_timer4", ia.round_timer, 4);
        do_tick();
        chk("r2_timeout_round", ia.round_cnt, 2);
        chk("r2_timeout_timer", ia.round_timer, 0);
        chk("r2_timeout_score", ia.score_bcd, 8'h01);
        hit = 1'b1; cyc(); hit = 1'b0; cyc();
        chk("r3_state", ia.state, 3);
        chk("r3_game_done", ia.game_done, 1);
        chk("r3_round", ia.round_cnt, 3);
        chk("r3_score", ia.score_bcd, 8'h02);
        cyc();
        chk("game_done_1cyc", ia.game_done, 0);
        chk("new_target_total", nt_a, 3);

        do_reset();
        press_start();
        peer = 1'b1; cyc(); peer = 1'b0;
        chk("b_game", ib.state, 2);
        for (int i = 0; i < 4; i++) do_tick();
        hit = 1'b1; cyc(); hit = 1'b0; tick = 1'b1; cyc(); tick = 1'b0;
        chk("simul_score", ib.score_bcd, 8'h01);
        chk("simul_round", ib.round_cnt, 1);
        chk("simul_timer", ib.round_timer, 0);
        cyc();

        for (int i = 0; i < 8; i++) do_hit();
        chk("score_09", ib.score_bcd, 8'h09);
        do_hit();
        chk("score_10", ib.score_bcd, 8'h10);
        for (int i = 0; i < 89; i++) do_hit();
        chk("score_99", ib.score_bcd, 8'h99);
        do_hit();
        chk("score_sat", ib.score_bcd, 8'h99);
        chk("round_100", ib.round_cnt, 100);

        do_tick();
        stop = 1'b1; cyc(); stop = 1'b0; cyc();
        chk("stop_state", ib.state, 3);
        chk("stop_game_done", ib.game_done, 1);
        chk("stop_round_kept", ib.round_cnt, 100);
        chk("stop_timer_kept", ib.round_timer, 1);
        chk("rgb_lag_game", ib.rgb_out, 12'h333);
        cyc();
        chk("rgb_score", ib.rgb_out, 12'h444);

        do_hit();
        chk("hit_in_score", ib.score_bcd, 8'h99);
        press_stop();
        chk("score_to_idle", ib.state, 0);
        chk("idle_score_held", ib.score_bcd, 8'h99);
        peer = 1'b1; cyc(); peer = 1'b0; cyc();
        chk("peer_in_idle", ib.state, 0);
        press_start();
        chk("clear_state", ib.state, 1);
        chk("clear_score", ib.score_bcd, 0);
        chk("clear_round", ib.round_cnt, 0);
        press_stop();
        chk("wait_stop", ib.state, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/game_ctl.md
Name: game_ctl

Overview:
- Parametrised successor of the game state controller for the duck-shooting VGA game.
- Sequences IDLE -> WAIT -> GAME -> SCORE and runs a configurable number of timed rounds.
- Counts hits into a BCD score and selects the per-state RGB stream for the sync/output stage.
- Sits between the click/mouse logic, the UART link, the per-state draw pipelines and the output sync stage.

Parameters:
ROUNDS, 10, number of rounds per game (1..255).
ROUND_FRAMES, 120, frames allowed per round before the target escapes (2..4095).
WAIT_FRAMES, 1800, frames to wait for peer start before returning to IDLE (2..65535).
SCORE_DIGITS, 2, BCD digits in score (1..4).

Ports:
pclk  in  1  pixel clock
rst  in  1  asynchronous active-low reset
frame_tick  in  1  one-cycle pulse per frame (vsync start)
start_click  in  1  level, play button clicked
peer_start  in  1  one-cycle pulse, peer ready over UART
hit  in  1  level, target clicked
stop_click  in  1  level, stop/back clicked
rgb_idle  in  12  IDLE screen pixel
rgb_wait  in  12  WAIT screen pixel
rgb_game  in  12  GAME screen pixel
rgb_score  in  12  SCORE screen pixel
state  out  2  0=IDLE 1=WAIT 2=GAME 3=SCORE
rgb_out  out  12  selected pixel
round_cnt  out  8  completed rounds in current game
round_timer  out  12  frames elapsed in current round
score_bcd  out  4*SCORE_DIGITS  hits, BCD, digit 0 in LSBs
new_target  out  1  one-cycle pulse, request new random target position
game_done  out  1  one-cycle pulse on GAME->SCORE

Behaviour:
Clock and reset:
- One clock, pclk.
- Reset is asynchronous and active-low.

Reset values:
- state=IDLE; rgb_out, round_cnt, round_timer, score_bcd, new_target, game_done all 0.
- Edge-detect history registers reset to 1, so a level held through reset does not fire.

Input edge detection:
- start_click, hit and stop_click act on rising edge only.
- Edge detection is internal, 1-cycle register.
- The event is acted on in the cycle after the input rises.

State transitions:
- IDLE: start edge -> WAIT. On entry, clear round_cnt, score_bcd, round_timer and the wait counter.
- WAIT:
  - peer_start -> GAME, with new_target pulsed the same cycle the state changes.
  - stop edge -> IDLE.
  - Each frame_tick increments the wait counter; at WAIT_FRAMES-1 on a tick -> IDLE.
  - peer_start wins over a simultaneous timeout.
- GAME:
  - frame_tick increments round_timer.
  - Round ends on the first hit edge (score += 1).
  - Round also ends on frame_tick while round_timer == ROUND_FRAMES-1 (no score).
  - Hit and timeout in the same cycle: hit wins, scored once.
  - Round end: round_timer <= 0, round_cnt += 1.
  - If the new round_cnt == ROUNDS -> SCORE with game_done pulse.
  - Otherwise new_target pulses and play continues.
  - Additional hit edges in the same cycle as a round end are ignored.
  - stop edge -> SCORE immediately (game_done pulses); round_cnt is not incremented.
- SCORE: values held; stop edge -> IDLE; start edge -> WAIT, with counters cleared.

Score arithmetic:
- Decimal ripple carry across digits.
- Saturates at all-9s; no wrap.

rgb_out:
- Registered mux on the current state register.
- Latency 1 cycle from rgb_* to rgb_out.
- The state change appears at rgb_out 1 cycle after state changes.

Event priority:
- stop > peer_start/hit > timeout.
- Ignored inputs in states that don't use them: hit outside GAME, peer_start outside WAIT.

Optional Feature:
Macro: GAME_CTL_SOLO_EN
- Defined: WAIT is bypassed. A start edge in IDLE or SCORE goes directly to GAME with new_target pulsed; peer_start is ignored; the wait counter is not built.
- Undefined: two-player flow as above.

Test Plan:
- Reset release with start_click held at 1 -> state stays 0. Drop then raise start_click -> state=1 two cycles later.
- WAIT_FRAMES=4, no peer_start, 4 frame_ticks -> state=0 after the 4th tick; peer_start before it -> state=2 and a 1-cycle new_target.
- ROUNDS=3, ROUND_FRAMES=5: hit in round 1, timeout in round 2, hit in round 3 -> score_bcd=0x02, round_cnt=3, game_done pulse, state=3, new_target pulsed 3 times in total.
- Hit edge in the same cycle as the timeout tick -> score increments by exactly 1, round_cnt by 1.
- Score preloaded via 99 hits (ROUNDS=120, SCORE_DIGITS=2), then 1 more hit -> score_bcd stays 0x99. Checks after 9 and 10 hits: 0x09 then 0x10.
- stop edge mid-round in GAME -> state=3 next cycle, game_done pulse, round_cnt unchanged. rgb_out switches from rgb_game to rgb_score one cycle after state.
